// File: rtl/cnn_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_defs (package)
//  Description : Shared types and constants for the CNN pipeline stages.
//  Revision    : 1.1 - pool_stream mode/state types and default window size
// ============================================================================
package cnn_defs;

  // Legacy fixed 2x2 max-pool stage state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } pool_state_t;

  localparam int c_pool_k_dflt = 2;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_t;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'd0,
    PS_RUN   = 2'd1,
    PS_DRAIN = 2'd2,
    PS_DONE  = 2'd3
  } pool_stream_state_t;

endpackage
`default_nettype wire

// File: rtl/pool_stream_lane.sv
`default_nettype none
// ============================================================================
//  Module      : pool_lane
//  Description : One channel of the pooling combine: first/max/add select and
//                the final average shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_lane
  import cnn_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 2,
  parameter int ACC_W      = DATA_WIDTH + SHIFT
) (
  input  logic                  first,
  input  pool_mode_t            mode,
  input  logic [ACC_W-1:0]      acc_in,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [ACC_W-1:0]      acc_next,
  output logic [DATA_WIDTH-1:0] result
);

  logic [ACC_W-1:0] w_sample;
  logic [ACC_W-1:0] w_max;
  logic [ACC_W-1:0] w_sum;

  assign w_sample = ACC_W'(sample);
  assign w_max    = (acc_in > w_sample) ? acc_in : w_sample;
  assign w_sum    = acc_in + w_sample;

  always_comb begin
    acc_next = w_sample;
    if (!first) begin
      acc_next = (mode == POOL_AVG) ? w_sum : w_max;
    end
  end

  // ACC_W is exactly DATA_WIDTH + SHIFT, so the slice is the truncating divide.
  assign result = (mode == POOL_AVG) ? w_sum[SHIFT +: DATA_WIDTH] : w_max[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/pool_stream.sv
`default_nettype none
// ============================================================================
//  Module      : pool_stream
//  Description : Streaming KxK max/average pooling engine over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_stream
  import cnn_defs::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int POOL_K     = c_pool_k_dflt,
  parameter int MAX_W      = 64,
  parameter int MAX_H      = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              cfg_mode,
  input  logic [$clog2(MAX_W+1)-1:0]        cfg_w,
  input  logic [$clog2(MAX_H+1)-1:0]        cfg_h,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]      in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(MAX_H/POOL_K)-1:0]   out_row,
  output logic [$clog2(MAX_W/POOL_K)-1:0]   out_col,
  output logic                              busy,
  output logic                              done
);

  localparam int c_cw        = $clog2(MAX_W+1);
  localparam int c_rw        = $clog2(MAX_H+1);
  localparam int c_log2k     = $clog2(POOL_K);
  localparam int c_shift     = 2*c_log2k;
  localparam int c_acc_w     = DATA_WIDTH + c_shift;
  localparam int c_entries   = MAX_W/POOL_K;
  localparam int c_col_idx_w = $clog2(MAX_W/POOL_K);
  localparam int c_row_idx_w = $clog2(MAX_H/POOL_K);

  pool_stream_state_t             r_state;
  pool_mode_t                     r_mode;
  logic [c_cw-1:0]                r_w;
  logic [c_rw-1:0]                r_h;
  logic [c_cw-1:0]                r_in_col;
  logic [c_rw-1:0]                r_in_row;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_out_valid;
  logic [NUM_CH*DATA_WIDTH-1:0]   r_out_data;
  logic [c_row_idx_w-1:0]         r_out_row;
  logic [c_col_idx_w-1:0]         r_out_col;
  logic [NUM_CH*c_acc_w-1:0]      r_acc [c_entries];

  logic                           w_accept;
  logic                           w_col_last;
  logic                           w_row_last;
  logic                           w_first;
  logic                           w_complete;
  logic [c_col_idx_w-1:0]         w_col_idx;
  logic [c_row_idx_w-1:0]         w_row_idx;
  logic [NUM_CH*c_acc_w-1:0]      w_acc_rd;
  logic [NUM_CH*c_acc_w-1:0]      w_acc_next;
  logic [NUM_CH*DATA_WIDTH-1:0]   w_result;

  // Input stalls only while a finished result is still waiting downstream.
  assign in_ready   = (r_state == PS_RUN) && !(r_out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_col_last = (r_in_col == r_w - c_cw'(1));
  assign w_row_last = (r_in_row == r_h - c_rw'(1));
  assign w_first    = (r_in_col[c_log2k-1:0] == '0) && (r_in_row[c_log2k-1:0] == '0);
  assign w_complete = (&r_in_col[c_log2k-1:0]) && (&r_in_row[c_log2k-1:0]);
  assign w_col_idx  = c_col_idx_w'(r_in_col >> c_log2k);
  assign w_row_idx  = c_row_idx_w'(r_in_row >> c_log2k);
  assign w_acc_rd   = r_acc[w_col_idx];

  generate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
      pool_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (c_shift),
        .ACC_W      (c_acc_w)
      ) u_lane (
        .first    (w_first),
        .mode     (r_mode),
        .acc_in   (w_acc_rd[ch*c_acc_w +: c_acc_w]),
        .sample   (in_data[ch*DATA_WIDTH +: DATA_WIDTH]),
        .acc_next (w_acc_next[ch*c_acc_w +: c_acc_w]),
        .result   (w_result[ch*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc[w_col_idx] <= w_acc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= PS_IDLE;
      r_mode   <= POOL_MAX;
      r_w      <= '0;
      r_h      <= '0;
      r_in_col <= '0;
      r_in_row <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        PS_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mode   <= pool_mode_t'(cfg_mode);
            r_w      <= cfg_w;
            r_h      <= cfg_h;
            r_in_col <= '0;
            r_in_row <= '0;
            r_busy   <= 1'b1;
            // An empty frame has no beats to wait for.
            r_state  <= ((cfg_w == '0) || (cfg_h == '0)) ? PS_DRAIN : PS_RUN;
          end
        end
        PS_RUN: begin
          if (w_accept) begin
            if (w_col_last) begin
              r_in_col <= '0;
              r_in_row <= r_in_row + c_rw'(1);
              if (w_row_last) begin
                r_state <= PS_DRAIN;
              end
            end else begin
              r_in_col <= r_in_col + c_cw'(1);
            end
          end
        end
        PS_DRAIN: begin
          if (!r_out_valid || out_ready) begin
            r_state <= PS_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= PS_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else if (w_accept && w_complete) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_row   <= w_row_idx;
      r_out_col   <= w_col_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pool_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_stream
//  Description : Directed self-checking bench for pool_stream (K=2 and K=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cfg_mode;
  logic [6:0]  cfg_w;
  logic [6:0]  cfg_h;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        sel_k4;

  logic        in_ready2, out_valid2, busy2, done2;
  logic [31:0] out_data2;
  logic [4:0]  out_row2, out_col2;
  logic        in_ready4, out_valid4, busy4, done4;
  logic [31:0] out_data4;
  logic [3:0]  out_row4, out_col4;

  wire logic        s_in_ready  = sel_k4 ? in_ready4  : in_ready2;
  wire logic        s_out_valid = sel_k4 ? out_valid4 : out_valid2;
  wire logic [31:0] s_out_data  = sel_k4 ? out_data4  : out_data2;
  wire logic [4:0]  s_out_row   = sel_k4 ? {1'b0, out_row4} : out_row2;
  wire logic [4:0]  s_out_col   = sel_k4 ? {1'b0, out_col4} : out_col2;
  wire logic        s_busy      = sel_k4 ? busy4 : busy2;
  wire logic        s_done      = sel_k4 ? done4 : done2;

  always #5 clk = ~clk;

  pool_stream #(.POOL_K(2)) dut2 (
    .clk(clk), .reset(reset), .start(start && !sel_k4), .cfg_mode(cfg_mode),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .in_valid(in_valid && !sel_k4), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_row(out_row2), .out_col(out_col2), .busy(busy2), .done(done2)
  );

  pool_stream #(.POOL_K(4)) dut4 (
    .clk(clk), .reset(reset), .start(start && sel_k4), .cfg_mode(cfg_mode),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .in_valid(in_valid && sel_k4), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_row(out_row4), .out_col(out_col4), .busy(busy4), .done(done4)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] cap_data[$];
  int          cap_rc[$];
  logic [31:0] seq1[$];
  int          done_cnt, beats, done_beats, done_cyc, last_out_cyc, stall_viol, stall_seen;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pix(input int pat, input int r, input int c, input int ch, input int w);
    int v;
    case (pat)
      0: case (ch) 0: v = r*w + c; 1: v = 255 - (r*w + c); 2: v = c*16; default: v = r*10; endcase
      1: case (ch) 0: v = r*w + c + 1; 1: v = 255; 2: v = c*60; default: v = r*70 + c; endcase
      default: v = r*37 + c*11 + ch*53 + ch*ch*7 + 3;
    endcase
    return v[7:0];
  endfunction

  function automatic logic [31:0] pix_word(input int pat, input int r, input int c, input int w);
    logic [31:0] word;
    for (int ch = 0; ch < 4; ch++) word[ch*8 +: 8] = pix(pat, r, c, ch, w);
    return word;
  endfunction

  function automatic logic [31:0] model_px(input int pat, input int w, input int mode, input int k,
                                           input int wr, input int wc);
    logic [31:0] res;
    int acc, mx, v;
    for (int ch = 0; ch < 4; ch++) begin
      acc = 0; mx = 0;
      for (int dr = 0; dr < k; dr++)
        for (int dc = 0; dc < k; dc++) begin
          v = int'(pix(pat, wr*k + dr, wc*k + dc, ch, w));
          acc += v;
          if (v > mx) mx = v;
        end
      res[ch*8 +: 8] = (mode != 0) ? 8'(acc / (k*k)) : 8'(mx);
    end
    return res;
  endfunction

  task automatic run_frame(input int w, input int h, input int mode, input int k, input int pat,
                           input int rnd, input int stall, input int abort_at);
    int cyc, left;
    logic [31:0] snap;
    bit have_snap;
    cap_data.delete(); cap_rc.delete();
    done_cnt = 0; beats = 0; done_beats = -1; done_cyc = -1; last_out_cyc = -1;
    stall_viol = 0; stall_seen = 0; have_snap = 0; snap = '0;
    left = (stall != 0) ? 10 : 0;
    sel_k4 = (k == 4); cfg_w = 7'(w); cfg_h = 7'(h); cfg_mode = (mode != 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      if (abort_at > 0 && beats == abort_at) break;
      in_valid  = (beats < w*h) && ((rnd != 0) ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data   = pix_word(pat, beats / w, beats % w, w);
      out_ready = (left > 0) ? 1'b0 : ((rnd != 0) ? ($urandom_range(0, 1) == 1) : 1'b1);
      @(negedge clk);
      if (left > 0 && s_out_valid) begin
        if (!have_snap) begin snap = s_out_data; have_snap = 1; end
        if (s_out_data !== snap || s_in_ready !== 1'b0) stall_viol++;
        stall_seen++; left--;
      end
      if (in_valid && s_in_ready) beats++;
      if (s_out_valid && out_ready) begin
        cap_data.push_back(s_out_data);
        cap_rc.push_back(int'(s_out_row)*256 + int'(s_out_col));
        last_out_cyc = cyc;
      end
      if (s_done) begin done_cnt++; done_cyc = cyc; done_beats = beats; end
      @(posedge clk); #1;
      cyc++;
      // Linger a few cycles past done to catch a repeated pulse.
      if (done_cyc >= 0 && cyc > done_cyc + 4) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    if (abort_at == 0) check_val("frame_completes", done_cyc >= 0, 1'b1);
  endtask

  task automatic check_frame(input string nm, input int w, input int h, input int mode, input int k, input int pat);
    int nr, nc, n;
    nr = h / k; nc = w / k; n = nr * nc;
    check_val($sformatf("%s n_out", nm), cap_data.size(), n);
    for (int i = 0; i < n && i < cap_data.size(); i++) begin
      check_val($sformatf("%s data[%0d]", nm, i), cap_data[i], model_px(pat, w, mode, k, i / nc, i % nc));
      check_val($sformatf("%s pos[%0d]", nm, i), cap_rc[i], (i / nc)*256 + (i % nc));
    end
    check_val($sformatf("%s done_count", nm), done_cnt, 1);
    check_val($sformatf("%s beats_at_done", nm), done_beats, w*h);
    check_val($sformatf("%s busy_idle", nm), s_busy, 1'b0);
  endtask

  task automatic check_ch0(input string nm, input int idx, input int exp);
    logic [31:0] word;
    word = (idx < cap_data.size()) ? cap_data[idx] : 32'hxxxx_xxxx;
    check_val(nm, word[7:0], exp);
  endtask

  initial begin
    logic [31:0] word;
    int dcount;
    reset = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_w = '0; cfg_h = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel_k4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outputs_k2", {in_ready2, out_valid2, busy2, done2, out_data2, out_row2, out_col2}, '0);
    check_val("reset_outputs_k4", {in_ready4, out_valid4, busy4, done4, out_data4, out_row4, out_col4}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // K=2 max 4x4, free flowing
    run_frame(4, 4, 0, 2, 0, 0, 0, 0);
    check_frame("max4x4", 4, 4, 0, 2, 0);
    check_ch0("max4x4 hand0", 0, 5);
    check_ch0("max4x4 hand1", 1, 7);
    check_ch0("max4x4 hand2", 2, 13);
    check_ch0("max4x4 hand3", 3, 15);
    check_val("max4x4 done_after_last_out", done_cyc > last_out_cyc, 1'b1);
    seq1 = cap_data;

    // K=2 average 4x4
    run_frame(4, 4, 1, 2, 1, 0, 0, 0);
    check_frame("avg4x4", 4, 4, 1, 2, 1);
    check_ch0("avg4x4 hand ch0", 0, 3);
    check_ch0("avg4x4 hand ch0 w3", 3, 13);
    word = (cap_data.size() > 0) ? cap_data[0] : 32'hxxxx_xxxx;
    check_val("avg4x4 all255", word[15:8], 8'd255);

    // K=4 max 5x6: one output, trailing column and rows discarded
    run_frame(5, 6, 0, 4, 2, 0, 0, 0);
    check_frame("k4_5x6", 5, 6, 0, 4, 2);
    check_ch0("k4_5x6 hand ch0", 0, 147);

    // Downstream stall for 10 cycles on the first output
    run_frame(4, 4, 0, 2, 0, 0, 1, 0);
    check_frame("stall", 4, 4, 0, 2, 0);
    check_val("stall viol", stall_viol, 0);
    check_val("stall cycles", stall_seen, 10);
    for (int i = 0; i < seq1.size() && i < cap_data.size(); i++)
      check_val($sformatf("stall vs free[%0d]", i), cap_data[i], seq1[i]);

    // Random valid/ready toggling
    run_frame(8, 6, 0, 2, 2, 1, 0, 0);
    check_frame("rnd_max", 8, 6, 0, 2, 2);
    run_frame(7, 5, 1, 2, 2, 1, 0, 0);
    check_frame("rnd_avg", 7, 5, 1, 2, 2);
    run_frame(9, 8, 1, 4, 2, 1, 0, 0);
    check_frame("rnd_k4_avg", 9, 8, 1, 4, 2);

    // Width below K: no outputs, beats still consumed
    run_frame(1, 3, 0, 2, 0, 0, 0, 0);
    check_frame("narrow", 1, 3, 0, 2, 0);

    // Abort mid-frame by reset after 7 beats
    run_frame(6, 4, 0, 2, 2, 0, 0, 7);
    check_val("abort beats", beats, 7);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort reset_outputs", {in_ready2, out_valid2, busy2, done2, out_data2, out_row2, out_col2}, '0);
    dcount = done_cnt + (done2 ? 1 : 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done2) dcount++;
    end
    check_val("abort no_done", dcount, 0);
    @(posedge clk); #1;
    run_frame(6, 4, 1, 2, 2, 1, 0, 0);
    check_frame("after_abort", 6, 4, 1, 2, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
